// File: rtl/fgba_shift_pkg.sv
// Shared constants and types for the barrel-shifter operand sequencer:
// shift-type codes, FSM state encoding, PC read offsets, decoded op2 fields.
package fgba_shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ_RM = 2'd1;
    localparam logic [1:0] ST_REQ_RS = 2'd2;
    localparam logic [1:0] ST_ISSUE  = 2'd3;

    // ARM7 pipeline: PC reads ahead by 8, or by 12 once the extra I-cycle is taken
    localparam logic [31:0] PC_OFS_IMM_DEFAULT = 32'd8;
    localparam logic [31:0] PC_OFS_REG_DEFAULT = 32'd12;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef struct packed {
        logic       is_imm;
        logic       is_reg_shift;
        logic [3:0] rm;
        logic [3:0] rs;
        logic [7:0] imm8;
        logic [3:0] rot4;
        logic [4:0] shimm5;
        logic [1:0] typ;
    } op2_fields_t;

endpackage

// File: rtl/op2_field_decode.sv
// Combinational split of a data-processing instruction's operand-2 field
// into the pieces the sequencer needs.
module op2_field_decode
    import fgba_shift_pkg::*;
(
    input  logic [31:0] instr,
    output op2_fields_t fields
);

    logic unused_bits;

    assign fields.is_imm       = instr[25];
    assign fields.is_reg_shift = ~instr[25] & instr[4];
    assign fields.rm           = instr[3:0];
    assign fields.rs           = instr[11:8];
    assign fields.imm8         = instr[7:0];
    assign fields.rot4         = instr[11:8];
    assign fields.shimm5       = instr[11:7];
    assign fields.typ          = instr[6:5];

    // Condition, opcode and Rd fields belong to other decode stages
    assign unused_bits = ^{instr[31:26], instr[24:12]};

endmodule

// File: rtl/shift_operand_seq.sv
// Operand sequencer in front of the barrel shifter: decodes op2, reads Rm/Rs
// from the register file and hands {base, amount, rg, typ, fc} over a valid/ready link.
module shift_operand_seq
    import fgba_shift_pkg::*;
#(
    parameter logic [31:0] PC_OFS_IMM = PC_OFS_IMM_DEFAULT,
    parameter logic [31:0] PC_OFS_REG = PC_OFS_REG_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        f_c_in,
    output logic [3:0]  rf_addr,
    output logic        rf_rd_en,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sh_base,
    output logic [7:0]  sh_amount,
    output logic        sh_rg,
    output logic [1:0]  sh_typ,
    output logic        sh_fc
);

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [3:0]  rm_q;
    logic [3:0]  rs_q;
    logic        reg_shift_q;
    op2_fields_t dec;
    logic        accept;
    logic [31:0] pc_imm;
    logic [31:0] pc_reg;

    op2_field_decode u_decode (
        .instr  (instr),
        .fields (dec)
    );

    assign in_ready  = (state == ST_IDLE) || ((state == ST_ISSUE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_ISSUE);
    assign rf_rd_en  = (state == ST_REQ_RM) || (state == ST_REQ_RS);
    assign pc_imm    = pc_q + PC_OFS_IMM;
    assign pc_reg    = pc_q + PC_OFS_REG;

    always_comb begin
        rf_addr = 4'd0;
        case (state)
            ST_REQ_RM: rf_addr = rm_q;
            ST_REQ_RS: rf_addr = rs_q;
            default:   rf_addr = 4'd0;
        endcase
    end

    // Accept can only occur in IDLE or on an ISSUE handshake, so it takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc_q        <= 32'd0;
            rm_q        <= 4'd0;
            rs_q        <= 4'd0;
            reg_shift_q <= 1'b0;
            sh_base     <= 32'd0;
            sh_amount   <= 8'd0;
            sh_rg       <= 1'b0;
            sh_typ      <= 2'b00;
            sh_fc       <= 1'b0;
        end else if (accept) begin
            pc_q        <= pc;
            rm_q        <= dec.rm;
            rs_q        <= dec.rs;
            reg_shift_q <= dec.is_reg_shift;
            sh_fc       <= f_c_in;
            sh_rg       <= dec.is_imm | dec.is_reg_shift;
            if (dec.is_imm) begin
                sh_base   <= {24'd0, dec.imm8};
                sh_amount <= {3'd0, dec.rot4, 1'b0};
                sh_typ    <= SH_ROR;
                state     <= ST_ISSUE;
            end else begin
                sh_base   <= 32'd0;
                sh_amount <= dec.is_reg_shift ? 8'd0 : {3'd0, dec.shimm5};
                sh_typ    <= dec.typ;
                state     <= ST_REQ_RM;
            end
        end else begin
            case (state)
                ST_REQ_RM: begin
                    if (rm_q == REG_PC) begin
                        sh_base <= reg_shift_q ? pc_reg : pc_imm;
                    end else begin
                        sh_base <= rf_data;
                    end
                    state <= reg_shift_q ? ST_REQ_RS : ST_ISSUE;
                end
                ST_REQ_RS: begin
                    sh_amount <= (rs_q == REG_PC) ? pc_reg[7:0] : rf_data[7:0];
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_operand_seq.sv
// Directed self-checking bench for shift_operand_seq with a behavioural
// register file answering combinational reads.
module tb_shift_operand_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        f_c_in;
    logic [3:0]  rf_addr;
    logic        rf_rd_en;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_base;
    logic [7:0]  sh_amount;
    logic        sh_rg;
    logic [1:0]  sh_typ;
    logic        sh_fc;

    logic [31:0] regs [16];
    int checks = 0;
    int passes = 0;

    assign rf_data = regs[rf_addr];

    always #5 clk = ~clk;

    shift_operand_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .f_c_in    (f_c_in),
        .rf_addr   (rf_addr),
        .rf_rd_en  (rf_rd_en),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_base   (sh_base),
        .sh_amount (sh_amount),
        .sh_rg     (sh_rg),
        .sh_typ    (sh_typ),
        .sh_fc     (sh_fc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            passes++;
    endtask

    // Issues one instruction from IDLE and waits (bounded) for out_valid,
    // recording latency and the register addresses read on the way.
    task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input logic c,
                                 output int lat, output logic [7:0] addrs, output int rd_cnt);
        @(negedge clk);
        instr = i; pc = p; f_c_in = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; addrs = 8'd0; rd_cnt = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rf_rd_en) begin
                addrs = {addrs[3:0], rf_addr};
                rd_cnt++;
            end
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic checkShift(input string tag, input logic [31:0] base, input logic [7:0] amt,
                              input logic [1:0] typ, input logic rg);
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_base"}, sh_base, base);
        checkOutput({tag, "_amount"}, {24'd0, sh_amount}, {24'd0, amt});
        checkOutput({tag, "_typ"}, {30'd0, sh_typ}, {30'd0, typ});
        checkOutput({tag, "_rg"}, {31'd0, sh_rg}, {31'd0, rg});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int rd_cnt;
        logic [7:0] addrs;

        for (int k = 0; k < 16; k++) regs[k] = 32'h1000_0000 + k;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; f_c_in = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_rd_en", {31'd0, rf_rd_en}, 32'd0);
        checkOutput("rst_base", sh_base, 32'd0);

        // Immediate rotate: 0xFF ror 8
        applyStimulus(32'hE3A004FF, 32'h100, 1'b1, lat, addrs, rd_cnt);
        checkOutput("imm_lat", lat, 32'd1);
        checkOutput("imm_reads", rd_cnt, 32'd0);
        checkShift("imm", 32'h0000_00FF, 8'd8, 2'b11, 1'b1);
        checkOutput("imm_fc", {31'd0, sh_fc}, 32'd1);

        // Back-to-back: new immediate accepted on the ISSUE handshake
        @(negedge clk);
        checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1 checkOutput("b2b_in_ready_hs", {31'd0, in_ready}, 32'd1);
        instr = 32'hE3A00C01; f_c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checkShift("b2b", 32'h0000_0001, 8'd24, 2'b11, 1'b1);
        checkOutput("b2b_fc", {31'd0, sh_fc}, 32'd0);
        consume();

        // Imm-shift: r2 LSL #2
        regs[2] = 32'h8000_0001;
        applyStimulus(32'hE1A00102, 32'h100, 1'b0, lat, addrs, rd_cnt);
        checkOutput("lsl_lat", lat, 32'd2);
        checkOutput("lsl_addr", {24'd0, addrs}, 32'h02);
        checkShift("lsl", 32'h8000_0001, 8'd2, 2'b00, 1'b0);
        consume();

        // LSR #0 stays encoded as zero
        applyStimulus(32'hE1A00022, 32'h100, 1'b0, lat, addrs, rd_cnt);
        checkShift("lsr0", 32'h8000_0001, 8'd0, 2'b01, 1'b0);
        consume();

        // Register shift: r2 LSL r3
        regs[2] = 32'h0000_0001;
        regs[3] = 32'h0000_0121;
        applyStimulus(32'hE1A00312, 32'h100, 1'b0, lat, addrs, rd_cnt);
        checkOutput("rsh_lat", lat, 32'd3);
        checkOutput("rsh_addr", {24'd0, addrs}, 32'h23);
        checkShift("rsh", 32'h0000_0001, 8'h21, 2'b00, 1'b1);

        // Backpressure: outputs frozen, no new accept
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_base", sh_base, 32'h0000_0001);
            checkOutput("bp_amount", {24'd0, sh_amount}, 32'h21);
        end
        consume();

        // PC as operand
        applyStimulus(32'hE1A0000F, 32'h0800_0000, 1'b0, lat, addrs, rd_cnt);
        checkShift("pc_imm", 32'h0800_0008, 8'd0, 2'b00, 1'b0);
        consume();
        applyStimulus(32'hE1A0031F, 32'h0800_0000, 1'b0, lat, addrs, rd_cnt);
        checkShift("pc_rm_reg", 32'h0800_000C, 8'h21, 2'b00, 1'b1);
        consume();
        applyStimulus(32'hE1A00F12, 32'h0800_0000, 1'b0, lat, addrs, rd_cnt);
        checkShift("pc_rs_reg", 32'h0000_0001, 8'h0C, 2'b00, 1'b1);
        consume();
        applyStimulus(32'hE1A0000F, 32'hFFFF_FFFC, 1'b0, lat, addrs, rd_cnt);
        checkShift("pc_wrap", 32'h0000_0004, 8'd0, 2'b00, 1'b0);
        consume();

        // Reset while in REQ_RS discards the instruction
        @(negedge clk);
        instr = 32'hE1A00312; pc = 32'h100; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rs_addr_before_rst", {28'd0, rf_addr}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_mid_rd_en", {31'd0, rf_rd_en}, 32'd0);
        checkOutput("rst_mid_amount", {24'd0, sh_amount}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_mid_no_out", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
